fifo_rd_packer: RTL
===================

# fifo_rd_packer

Read-side consumer for the asynchronous FIFO, operating entirely in the FIFO's read clock domain. It pops DSIZE-bit entries through the FIFO's `rinc`/`rempty`/`rdata` port and packs PACK consecutive entries into one wide word. Each packed word is presented on a registered valid/ready output stream. A flush request emits a partial word with a lane-keep mask, so trailing data never sits stranded.

## Interface
- `DSIZE`, 8: width of one FIFO entry; must equal the FIFO's data width.
- `PACK`, 4: entries per output word (power of two, 2..8).
- `rclk  in  1`: read-domain clock; the only clock of this block.
- `rrst_n  in  1`: reset. Synchronous and active-low: sampled on the rising edge of `rclk`.
- `rdata  in  DSIZE`: FIFO read data; valid whenever `rempty`=0.
- `rempty  in  1`: FIFO empty flag.
- `rinc  out  1`: FIFO pop strobe; combinational.
- `flush  in  1`: single-cycle request to emit the partial word.
- `m_data  out  DSIZE*PACK`: packed word. Lane i is bits [i*DSIZE +: DSIZE]; lane 0 holds the first entry popped.
- `m_keep  out  PACK`: lane-valid mask for `m_data`.
- `m_valid  out  1`: output word valid.
- `m_ready  in  1`: downstream accept.

## Operation
- Internal state:
  - `acc`: PACK-1 lanes of DSIZE bits.
  - `cnt`: 0..PACK-1, number of lanes filled.
  - `fpend`: flush pending.
  - Output register `{m_data, m_keep, m_valid}`.
- `out_free` = !m_valid | m_ready.
- `rinc` = !rempty & !fpend & !flush & ((cnt != PACK-1) | out_free).
- Pop with cnt < PACK-1: `acc[cnt]` <= rdata; cnt <= cnt+1.
- Pop with cnt = PACK-1 (completing pop):
  - Output register loads {rdata, acc lanes PACK-2..0}.
  - m_keep <= all ones; m_valid <= 1; cnt <= 0.
- Handshake: a word transfers on an edge where m_valid & m_ready.
  - If that edge does not load a new word, m_valid <= 0.
  - m_data/m_keep stay stable while m_valid & !m_ready.
- Flush states: NORMAL (fpend=0) and FLUSHING (fpend=1).
  - NORMAL -> FLUSHING on `flush`=1. No pop occurs in that cycle.
  - In FLUSHING with cnt = 0: return to NORMAL next edge; nothing is emitted.
  - In FLUSHING with cnt > 0 and out_free:
    - Output loads acc lanes 0..cnt-1, upper lanes zero.
    - m_keep = (1<<cnt)-1; m_valid <= 1; cnt <= 0; return to NORMAL.
  - In FLUSHING with cnt > 0 and !out_free: hold.
  - `flush` asserted while fpend=1 is absorbed; no second partial word is emitted.
- `rempty`=1: no pop. `acc`/`cnt` hold indefinitely; no timeout.
- Reset (rrst_n=0 at an edge):
  - cnt=0, fpend=0, m_valid=0, m_data=0, m_keep=0, acc=0.
  - `rinc` is forced 0 during reset.
- Reset mid-operation discards the partial word and any held output word. The FIFO contents are untouched.

## Timing
- `rinc` is combinational from `rempty`, `flush`, `m_ready` and state. The FIFO pointer advances on the same `rclk` edge on which `rdata` is captured.
- Throughput: one pop per cycle when the FIFO is non-empty and the output is not stalled. This gives one word per PACK cycles.
- Latency: m_valid rises on the edge of the completing pop. For a non-empty FIFO, the word is visible after the PACK-th edge.
- Back-to-back words: if m_ready=1 on the completing-pop edge, the old word transfers and the new word loads on the same edge. There are no bubbles.
- Stall: m_valid & !m_ready blocks only the completing pop. Fill pops continue up to cnt = PACK-1.
- Flush latency:
  - Flush at edge k (cnt>0, out_free): partial word valid after edge k+1.
  - Popping resumes at cycle k+1 only if the flush emitted or cnt=0. Otherwise it resumes after the emitting edge.

## Test plan
- Reset, then write 0x00..0x0F to the FIFO with m_ready=1. Required response:
  - Four words: 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, all with m_keep=0xF.
  - Exactly 16 `rinc` pulses.
  - `rempty`=1 at the end.
- Backpressure: 8 entries 0x10..0x17 with m_ready=0 for 10 cycles. Required response:
  - First word 0x13121110 is held stable.
  - cnt saturates at 3, rinc=0, 0x17 stays in the FIFO.
  - Raise m_ready: the second word 0x17161514 follows within 2 cycles.
- Partial flush: write 0xA1, 0xA2, then pulse flush. Required response: m_data=0x0000A2A1, m_keep=0x3, one word only.
- Flush with cnt=0, and flush pulsed on the same edge rempty deasserts. Required response:
  - No output word.
  - No pop in the flush cycle.
  - Normal packing resumes afterwards.
- Reset mid-word: pop 0x55, 0x66, then rrst_n=0 for 1 cycle. Required response:
  - All outputs are 0.
  - Next entries 0x01..0x04 produce exactly 0x04030201 with m_keep=0xF.
- Random FIFO fill and random m_ready for 1000 entries. Required response:
  - Output byte stream equals input order.
  - No word lost or duplicated.
  - m_data stable whenever m_valid & !m_ready.

Source files
------------

// File: rtl/fifo_rd_packer_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer_if
//   Bundles the signals of fifo_rd_packer that are not clock or reset:
//   the read port of the asynchronous FIFO and the packed output stream.
//
//   FIFO read side:
//     rdata   [DSIZE]       FIFO head entry, valid while rempty = 0
//     rempty                FIFO empty flag
//     rinc                  pop strobe (driven by the packer)
//     flush                 single-cycle request to emit a partial word
//   Packed output stream:
//     m_data  [DSIZE*PACK]  packed word, lane 0 = first entry popped
//     m_keep  [PACK]        lane-valid mask
//     m_valid               word valid
//     m_ready               downstream accept
//
//   Modports:
//     master : the packer itself
//     slave  : the environment (FIFO read port plus downstream consumer)
// -----------------------------------------------------------------------------
interface fifo_rd_packer_if #(
    parameter int DSIZE = 8,
    parameter int PACK  = 4
) ();

    logic [DSIZE-1:0]      rdata;
    logic                  rempty;
    logic                  rinc;
    logic                  flush;
    logic [DSIZE*PACK-1:0] m_data;
    logic [PACK-1:0]       m_keep;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        input  rdata,
        input  rempty,
        input  flush,
        input  m_ready,
        output rinc,
        output m_data,
        output m_keep,
        output m_valid
    );

    modport slave (
        output rdata,
        output rempty,
        output flush,
        output m_ready,
        input  rinc,
        input  m_data,
        input  m_keep,
        input  m_valid
    );

endinterface

// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
//   Read-side consumer of the asynchronous FIFO, clocked only by the FIFO read
//   clock. Pops DSIZE-bit entries and packs PACK consecutive entries into one
//   wide word presented on a registered valid/ready stream. A flush request
//   emits whatever lanes are already collected as a partial word with a
//   lane-keep mask.
//
//   Parameters:
//     DSIZE  width of one FIFO entry
//     PACK   entries per output word (power of two, 2..8)
//
//   Ports:
//     rclk    read-domain clock
//     rrst_n  synchronous active-low reset
//     rd      fifo_rd_packer_if.master: rdata/rempty/rinc/flush and
//             m_data/m_keep/m_valid/m_ready
//
//   rinc is combinational so the FIFO pointer advances on the same edge that
//   captures rdata; all stream outputs are registered.
// -----------------------------------------------------------------------------
module fifo_rd_packer #(
    parameter int DSIZE = 8,
    parameter int PACK  = 4
) (
    input  logic             rclk,
    input  logic             rrst_n,
    fifo_rd_packer_if.master rd
);

    localparam int              CW       = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int              WW       = DSIZE * PACK;
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(PACK - 1);

    // NORMAL: popping allowed. FLUSHING: a flush is pending, popping paused
    // until the partial word has been loaded (or there was nothing to emit).
    typedef enum logic [0:0] {
        ST_NORMAL   = 1'b0,
        ST_FLUSHING = 1'b1
    } flush_state_t;

    flush_state_t                    state_r;
    flush_state_t                    state_nxt_s;
    logic [CW-1:0]                   cnt_r;
    logic [CW-1:0]                   cnt_nxt_s;
    logic [PACK-2:0][DSIZE-1:0]      acc_r;

    logic [WW-1:0]                   m_data_r;
    logic [PACK-1:0]                 m_keep_r;
    logic                            m_valid_r;

    logic                            out_free_s;
    logic                            last_s;
    logic                            rinc_s;
    logic                            fill_pop_s;
    logic                            full_pop_s;
    logic                            flush_emit_s;
    logic                            load_s;
    logic [WW-1:0]                   full_data_s;
    logic [WW-1:0]                   partial_data_s;
    logic [PACK-1:0]                 partial_keep_s;
    logic [WW-1:0]                   load_data_s;
    logic [PACK-1:0]                 load_keep_s;

    // Pop and load qualifiers.
    always_comb begin
        out_free_s   = !m_valid_r || rd.m_ready;
        last_s       = (cnt_r == CNT_LAST);
        // Only the completing pop needs room in the output register; fill
        // pops keep going while the output stalls. rrst_n gates the strobe
        // so the FIFO is never popped during reset.
        rinc_s       = rrst_n && !rd.rempty && (state_r == ST_NORMAL) &&
                       !rd.flush && (!last_s || out_free_s);
        fill_pop_s   = rinc_s && !last_s;
        full_pop_s   = rinc_s && last_s;
        flush_emit_s = (state_r == ST_FLUSHING) && (cnt_r != CNT_ZERO) &&
                       out_free_s;
        load_s       = full_pop_s || flush_emit_s;
    end

    // Flush FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_NORMAL: begin
                if (rd.flush) begin
                    state_nxt_s = ST_FLUSHING;
                end else begin
                    state_nxt_s = ST_NORMAL;
                end
            end
            ST_FLUSHING: begin
                // Further flush pulses here are absorbed: leaving FLUSHING
                // depends only on the fill count and output room.
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_NORMAL;
                end else if (out_free_s) begin
                    state_nxt_s = ST_NORMAL;
                end else begin
                    state_nxt_s = ST_FLUSHING;
                end
            end
            default: begin
                state_nxt_s = ST_NORMAL;
            end
        endcase
    end

    // Fill-count next value.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (load_s) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (fill_pop_s) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Candidate words: full word (accumulator + current rdata in the top lane)
    // and partial word (filled lanes only, upper lanes zero).
    always_comb begin
        full_data_s    = {WW{1'b0}};
        partial_data_s = {WW{1'b0}};
        partial_keep_s = {PACK{1'b0}};
        for (int i = 0; i < PACK - 1; i++) begin
            full_data_s[i*DSIZE +: DSIZE] = acc_r[i];
            if (CW'(i) < cnt_r) begin
                partial_data_s[i*DSIZE +: DSIZE] = acc_r[i];
                partial_keep_s[i]                = 1'b1;
            end else begin
                partial_data_s[i*DSIZE +: DSIZE] = {DSIZE{1'b0}};
                partial_keep_s[i]                = 1'b0;
            end
        end
        full_data_s[(PACK-1)*DSIZE +: DSIZE] = rd.rdata;
        // cnt never reaches PACK, so the top lane is never part of a partial.
        partial_keep_s[PACK-1]               = 1'b0;
    end

    // Select the word loaded into the output register.
    always_comb begin
        load_data_s = partial_data_s;
        load_keep_s = partial_keep_s;
        if (full_pop_s) begin
            load_data_s = full_data_s;
            load_keep_s = {PACK{1'b1}};
        end else begin
            load_data_s = partial_data_s;
            load_keep_s = partial_keep_s;
        end
    end

    // Flush FSM state register and fill count.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state_r <= ST_NORMAL;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Accumulator lanes: a fill pop writes rdata into lane cnt.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            acc_r <= {((PACK-1)*DSIZE){1'b0}};
        end else begin
            for (int i = 0; i < PACK - 1; i++) begin
                if (fill_pop_s && (cnt_r == CW'(i))) begin
                    acc_r[i] <= rd.rdata;
                end
            end
        end
    end

    // Output register: load wins over transfer so back-to-back words have no
    // bubble; data/keep are untouched while a word waits for m_ready.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            m_data_r  <= {WW{1'b0}};
            m_keep_r  <= {PACK{1'b0}};
            m_valid_r <= 1'b0;
        end else if (load_s) begin
            m_data_r  <= load_data_s;
            m_keep_r  <= load_keep_s;
            m_valid_r <= 1'b1;
        end else if (m_valid_r && rd.m_ready) begin
            m_valid_r <= 1'b0;
        end
    end

    assign rd.rinc    = rinc_s;
    assign rd.m_data  = m_data_r;
    assign rd.m_keep  = m_keep_r;
    assign rd.m_valid = m_valid_r;

endmodule
